seg7_capture_decoder: RTL and testbench
=======================================

// Module: seg7_capture_decoder
// PURPOSE
//  Inverse of the hex-to-seven-segment decoder: watches an active-low 7-seg bus
//  (seg[0]=a .. seg[6]=g) and recovers the displayed hex digit.
//  Each candidate pattern must be stable for STABLE_CYCLES samples before it is accepted.
//  Each new accepted digit is queued in a small FIFO read out over a valid/ready handshake.
//  Used by display self-check logic and testbenches to read back what the HEX panels show.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive identical samples required to accept a pattern (>=1)
//  DEPTH          4  FIFO entries (power of two, >=2)
// PORTS
//  clk         in   1   clock; all state updates on rising edge
//  reset       in   1   synchronous, active-high reset
//  seg_in      in   7   active-low segment pattern {g,f,e,d,c,b,a}
//  out_valid   out  1   FIFO non-empty; head entry presented
//  out_ready   in   1   consumer accepts head when out_valid&out_ready
//  out_hex     out  4   decoded digit of head entry (0 when out_err or empty)
//  out_err     out  1   head entry was an unrecognised pattern
//  fifo_count  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
//  overflow    out  1   sticky: an accepted digit was dropped because FIFO full
// BEHAVIOUR
//  Reset (sync, one edge): sample_q=7'h7F, cand=7'h7F, cnt=0, last_acc=7'h7F, FIFO empty;
//   out_valid=0, out_hex=0, out_err=0, fifo_count=0, overflow=0. Reset mid-operation discards FIFO.
//  Stage 1: sample_q <= seg_in every cycle (no other use of raw seg_in).
//  Stage 2 stability filter: if sample_q!=cand: cand<=sample_q, cnt<=1;
//   else if cnt<STABLE_CYCLES: cnt<=cnt+1 (saturates at STABLE_CYCLES).
//  Accept: when cnt==STABLE_CYCLES && cand!=last_acc -> last_acc<=cand; same edge:
//   cand==7'h7F (blank) -> no push (blank only re-arms so a repeated digit is caught again);
//   else push {err,hex} = decode(cand).
//  Decode table (seg_in hex -> digit): 40->0 79->1 24->2 30->3 19->4 12->5 02->6 78->7
//   00->8 18->9 08->A 03->b 46->C 21->d 06->E 0E->F; any other -> err=1, hex=0.
//  Latency: seg_in held from edge N -> out_valid=1 after edge N+STABLE_CYCLES+1
//   (STABLE_CYCLES+2 edges incl. N), provided FIFO was empty.
//  A pattern held indefinitely yields exactly one entry; glitch shorter than
//   STABLE_CYCLES samples yields none and restarts the filter.
//  FIFO: in-order; pop when out_valid&&out_ready; out_hex/out_err driven from head
//   combinationally, 0 when empty. Push with count==DEPTH and no pop -> entry dropped,
//   overflow<=1 (held until reset), count unchanged. Push+pop same cycle when full ->
//   both succeed, count stays DEPTH, no overflow. Push+pop when empty: push only (no
//   bypass; out_valid low that cycle). Pointers wrap modulo DEPTH.
//  out_ready while out_valid=0 is ignored.
// TESTING
//  1 Reset, seg_in=7'h7F 20 cycles -> out_valid=0, fifo_count=0, overflow=0.
//  2 seg_in=7'h24 from edge 0, out_ready=0 -> out_valid rises after edge 5;
//    out_hex=2, out_err=0; after 30 cycles fifo_count still 1.
//  3 7'h24 for 3 cycles then 7'h30 held -> single entry hex=3, no entry for 2.
//  4 7'h12 held 8, 7'h7F held 8, 7'h12 held 8 -> two entries 5,5;
//    7'h12 then 7'h02 with no blank -> entries 5,6.
//  5 seg_in=7'h55 held -> entry out_err=1, out_hex=0; all 16 table codes -> correct digits.
//  6 DEPTH=4, out_ready=0, accept 1,2,3,4,5 -> fifo_count=4, overflow=1; drain with
//    out_ready=1 -> 1,2,3,4 in order; refill to 4, pop on accept edge -> count 4, overflow
//    unchanged; assert reset with 3 queued -> next cycle count=0, out_valid=0, overflow=0.

Source files
------------

// File: rtl/seg7_capture_decoder.sv
// Recovers hex digits from an active-low 7-segment bus. Each pattern must hold
// for STABLE_CYCLES samples before it is accepted, and accepted digits queue in a small FIFO.
module seg7_capture_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [6:0]               seg_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_hex,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [6:0]    BLANK = 7'h7F;

  // Result is {err, hex}; unrecognised patterns report err with hex forced to 0.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40: decode = 5'h00;
      7'h79: decode = 5'h01;
      7'h24: decode = 5'h02;
      7'h30: decode = 5'h03;
      7'h19: decode = 5'h04;
      7'h12: decode = 5'h05;
      7'h02: decode = 5'h06;
      7'h78: decode = 5'h07;
      7'h00: decode = 5'h08;
      7'h18: decode = 5'h09;
      7'h08: decode = 5'h0A;
      7'h03: decode = 5'h0B;
      7'h46: decode = 5'h0C;
      7'h21: decode = 5'h0D;
      7'h06: decode = 5'h0E;
      7'h0E: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  logic [6:0]    sample_q;
  logic [6:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    last_acc_q, last_acc_d;
  logic [4:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic accept, push, pop, full, do_push;

  assign accept  = (cnt_q == CNT_MAX) && (cand_q != last_acc_q);
  // A blank only re-arms the detector so a repeated digit is captured again.
  assign push    = accept && (cand_q != BLANK);
  assign pop     = (count_q != '0) && out_ready;
  assign full    = (count_q == FULL_CNT);
  assign do_push = push && (!full || pop);

  always_comb begin
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    last_acc_d = last_acc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (sample_q != cand_q) begin
      cand_d = sample_q;
      cnt_d  = CW'(1);
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end

    if (accept) last_acc_d = cand_q;

    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!do_push && pop) count_d = count_q - (AW+1)'(1);
    if (push && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q   <= BLANK;
      cand_q     <= BLANK;
      cnt_q      <= '0;
      last_acc_q <= BLANK;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      sample_q   <= seg_in;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      last_acc_q <= last_acc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the head is only visible while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= decode(cand_q);
  end

  assign out_valid  = (count_q != '0);
  assign out_hex    = out_valid ? mem_q[rd_ptr_q][3:0] : 4'h0;
  assign out_err    = out_valid ? mem_q[rd_ptr_q][4]   : 1'b0;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Self-checking bench for seg7_capture_decoder: directed vectors, corner sequences,
// and random stimulus compared each cycle against a run-length based reference model.
module tb_seg7_capture_decoder;

  localparam int S = 4;
  localparam int D = 4;
  localparam logic [6:0] PAT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_hex;
  logic       out_err;
  logic [2:0] fifo_count;
  logic       overflow;

  seg7_capture_decoder #(.STABLE_CYCLES(S), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_hex(out_hex), .out_err(out_err),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] hex;
    logic       err;
  } vec_t;
  vec_t vecs [19];

  // Reference model: the display is read as runs of identical samples seen two
  // edges late; a run of at least S samples is accepted once if it differs from
  // the previously accepted run.
  logic [6:0] m_d1, m_run_val, m_last;
  int         m_run_len;
  logic [4:0] m_q [$];
  bit         m_ovf;

  function automatic logic [4:0] m_decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (PAT[i] == p) return {1'b0, 4'(i)};
    return 5'h10;
  endfunction

  task automatic model_reset();
    m_d1 = 7'h7F; m_run_val = 7'h7F; m_last = 7'h7F; m_run_len = 0;
    m_q.delete(); m_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic [6:0] s, input logic rdy);
    bit pop_ok, was_full, acc, psh;
    pop_ok   = (m_q.size() > 0) && rdy;
    was_full = (m_q.size() == D);
    acc      = (m_run_len >= S) && (m_run_val != m_last);
    psh      = acc && (m_run_val != 7'h7F);
    if (acc) m_last = m_run_val;
    if (pop_ok) void'(m_q.pop_front());
    if (psh) begin
      if (was_full && !pop_ok) m_ovf = 1'b1;
      else m_q.push_back(m_decode(m_run_val));
    end
    if (m_d1 == m_run_val) begin
      if (m_run_len < 1000) m_run_len++;
    end else begin
      m_run_val = m_d1;
      m_run_len = 1;
    end
    m_d1 = s;
  endtask

  task automatic compare_model();
    logic       ev, ee, eo;
    logic [3:0] eh;
    logic [2:0] ec;
    ev = (m_q.size() > 0);
    eh = ev ? m_q[0][3:0] : 4'h0;
    ee = ev ? m_q[0][4] : 1'b0;
    ec = 3'(m_q.size());
    eo = m_ovf;
    n_checks++;
    if (out_valid !== ev || out_hex !== eh || out_err !== ee || fifo_count !== ec || overflow !== eo) begin
      n_fail++;
      $display("FAIL model t=%0t got valid=%b hex=%h err=%b cnt=%0d ovf=%b expected valid=%b hex=%h err=%b cnt=%0d ovf=%b",
               $time, out_valid, out_hex, out_err, fifo_count, overflow, ev, eh, ee, ec, eo);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic [6:0] s, input logic rdy);
    seg_in    = s;
    out_ready = rdy;
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(s, rdy);
    #1;
    compare_model();
  endtask

  task automatic hold(input logic [6:0] s, input int n, input logic rdy);
    repeat (n) tick(s, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(7'h7F, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      vecs[i].seg = PAT[i]; vecs[i].hex = 4'(i); vecs[i].err = 1'b0;
    end
    vecs[16] = '{seg: 7'h55, hex: 4'h0, err: 1'b1};
    vecs[17] = '{seg: 7'h7E, hex: 4'h0, err: 1'b1};
    vecs[18] = '{seg: 7'h01, hex: 4'h0, err: 1'b1};

    reset = 1'b0; seg_in = 7'h7F; out_ready = 1'b0;
    model_reset();
    #1;

    // Idle after reset
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_hex", out_hex, 0);
    hold(7'h7F, 20, 1'b0);
    chk("idle_valid", out_valid, 0);
    chk("idle_count", fifo_count, 0);
    chk("idle_ovf", overflow, 0);

    // Acceptance latency
    do_reset();
    for (int e = 0; e < S + 1; e++) begin
      tick(7'h24, 1'b0);
      chk("lat_early_valid", out_valid, 0);
    end
    tick(7'h24, 1'b0);
    chk("lat_valid", out_valid, 1);
    chk("lat_hex", out_hex, 2);
    chk("lat_err", out_err, 0);
    hold(7'h24, 30, 1'b0);
    chk("held_once_count", fifo_count, 1);

    // Short glitch is ignored
    do_reset();
    hold(7'h24, 3, 1'b0);
    hold(7'h30, 10, 1'b0);
    chk("glitch_count", fifo_count, 1);
    chk("glitch_hex", out_hex, 3);

    // Blank re-arms a repeated digit
    do_reset();
    hold(7'h12, 8, 1'b0);
    hold(7'h7F, 8, 1'b0);
    hold(7'h12, 8, 1'b0);
    chk("rearm_count", fifo_count, 2);
    chk("rearm_hex0", out_hex, 5);
    tick(7'h12, 1'b1);
    chk("rearm_hex1", out_hex, 5);
    chk("rearm_count1", fifo_count, 1);

    do_reset();
    hold(7'h12, 8, 1'b0);
    hold(7'h02, 8, 1'b0);
    chk("noblank_count", fifo_count, 2);
    chk("noblank_hex0", out_hex, 5);
    tick(7'h02, 1'b1);
    chk("noblank_hex1", out_hex, 6);

    // Decode table
    foreach (vecs[i]) begin
      do_reset();
      hold(vecs[i].seg, S + 2, 1'b0);
      chk($sformatf("dec_valid_%02h", vecs[i].seg), out_valid, 1);
      chk($sformatf("dec_hex_%02h", vecs[i].seg), out_hex, vecs[i].hex);
      chk($sformatf("dec_err_%02h", vecs[i].seg), out_err, vecs[i].err);
    end

    // Overflow, drain, pop on a full accept edge, reset mid-operation
    do_reset();
    for (int d = 1; d <= 5; d++) hold(PAT[d], 7, 1'b0);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
    for (int d = 1; d <= 4; d++) begin
      chk($sformatf("drain_hex_%0d", d), out_hex, 4'(d));
      tick(PAT[5], 1'b1);
    end
    chk("drain_empty", out_valid, 0);
    chk("drain_ovf_sticky", overflow, 1);
    for (int d = 6; d <= 9; d++) hold(PAT[d], 7, 1'b0);
    chk("refill_count", fifo_count, 4);
    hold(PAT[10], S + 1, 1'b0);
    tick(PAT[10], 1'b1);
    chk("fullpp_count", fifo_count, 4);
    chk("fullpp_ovf", overflow, 1);
    chk("fullpp_head", out_hex, 7);

    do_reset();
    for (int d = 6; d <= 9; d++) hold(PAT[d], 7, 1'b0);
    hold(PAT[10], S + 1, 1'b0);
    tick(PAT[10], 1'b1);
    chk("fullpp2_count", fifo_count, 4);
    chk("fullpp2_ovf", overflow, 0);
    tick(PAT[10], 1'b1);
    chk("pre_rst_count", fifo_count, 3);
    reset = 1'b1;
    tick(PAT[10], 1'b0);
    reset = 1'b0;
    chk("midrst_count", fifo_count, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ovf", overflow, 0);

    // Random stimulus against the model
    do_reset();
    for (int seg_n = 0; seg_n < 700; seg_n++) begin
      logic [6:0] s;
      int         len, sel, rmode;
      sel = $urandom_range(0, 9);
      if (sel < 6)      s = PAT[$urandom_range(0, 15)];
      else if (sel < 8) s = 7'h7F;
      else              s = 7'($urandom);
      len   = $urandom_range(1, 8);
      rmode = $urandom_range(0, 2);
      for (int k = 0; k < len; k++) begin
        logic rdy;
        case (rmode)
          0: rdy = 1'b0;
          1: rdy = ($urandom_range(0, 3) == 0);
          default: rdy = ($urandom_range(0, 1) == 0);
        endcase
        reset = ($urandom_range(0, 299) == 0);
        tick(s, rdy);
      end
      reset = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
